// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: lights one of four moles per round, judges
// button presses as hit or miss, keeps score/miss counts and ends the game.
module mole_scheduler #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned UP_TICKS  = 2,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned ROUNDS    = 20,
    parameter int unsigned MAX_MISS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rnd_num,
    input  logic [3:0] btn,
    output logic [3:0] mole,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       busy,
    output logic       game_over,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    localparam int unsigned GAP_LEN = GAP_TICKS * TICK_DIV;
    localparam int unsigned UP_LEN  = UP_TICKS * TICK_DIV;
    localparam int unsigned MAX_LEN = (GAP_LEN > UP_LEN) ? GAP_LEN : UP_LEN;
    localparam int unsigned TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          start_q;
    logic [3:0]    btn_q;
    logic [TW-1:0] timer;
    logic [7:0]    round;
    logic [1:0]    prev_idx;
    logic          have_prev;

    logic          start_rise;
    logic [3:0]    btn_edge;
    logic [1:0]    pick;
    logic [3:0]    pick_mask;
    logic          gap_end;
    logic          up_end;
    logic          pressed;
    logic          is_hit;
    logic          judged;
    logic [7:0]    round_nxt;
    logic [3:0]    misses_nxt;
    logic          game_end;

    // Edge detection, mole selection with no-repeat, and round judgement
    always_comb begin
        start_rise = start & ~start_q;
        btn_edge   = btn & ~btn_q;
        pick       = rnd_num;
        if (have_prev && (rnd_num == prev_idx)) begin
            pick = rnd_num + 2'd1;
        end
        pick_mask  = 4'b0001 << pick;
        gap_end    = (timer == TW'(GAP_LEN - 1));
        up_end     = (timer == TW'(UP_LEN - 1));
        pressed    = |btn_edge;
        is_hit     = pressed && (btn_edge == mole);
        judged     = pressed || up_end;
        round_nxt  = round + 8'd1;
        misses_nxt = is_hit ? misses : (misses + 4'd1);
        game_end   = (round_nxt == 8'(ROUNDS)) || (misses_nxt == 4'(MAX_MISS));
    end

    // Game state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            btn_q      <= 4'd0;
            timer      <= '0;
            round      <= 8'd0;
            prev_idx   <= 2'd0;
            have_prev  <= 1'b0;
            mole       <= 4'd0;
            score      <= 8'd0;
            misses     <= 4'd0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            start_q    <= start;
            btn_q      <= btn;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        score     <= 8'd0;
                        misses    <= 4'd0;
                        round     <= 8'd0;
                        timer     <= '0;
                        have_prev <= 1'b0;
                        mole      <= 4'd0;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        mole      <= pick_mask;
                        prev_idx  <= pick;
                        have_prev <= 1'b1;
                        timer     <= '0;
                        state     <= SHOW;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SHOW: begin
                    if (judged) begin
                        mole  <= 4'd0;
                        round <= round_nxt;
                        timer <= '0;
                        if (is_hit) begin
                            hit_pulse <= 1'b1;
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
                        end else begin
                            miss_pulse <= 1'b1;
                            misses     <= misses_nxt;
                        end
                        if (game_end) begin
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed self-checking bench for mole_scheduler (GAP = 8 cycles, SHOW = 12 cycles).
module tb_mole_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] rnd_num;
    logic [3:0] btn;
    logic [3:0] mole;
    logic [7:0] score;
    logic [3:0] misses;
    logic       busy;
    logic       game_over;
    logic       hit_pulse;
    logic       miss_pulse;

    int compared;
    int mismatched;

    mole_scheduler #(
        .TICK_DIV (4),
        .UP_TICKS (3),
        .GAP_TICKS(2),
        .ROUNDS   (4),
        .MAX_MISS (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rnd_num   (rnd_num),
        .btn       (btn),
        .mole      (mole),
        .score     (score),
        .misses    (misses),
        .busy      (busy),
        .game_over (game_over),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; sample point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        start   = 1'b0;
        btn     = 4'd0;
        rnd_num = 2'd0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // steps until a mole lights; returns cycles taken (bounded)
    task automatic wait_mole(output int n);
        n = 0;
        while (mole == 4'd0 && n < 60) begin
            step();
            n++;
        end
        if (mole == 4'd0) begin
            compared++;
            mismatched++;
            $display("FAIL wait_mole: no mole after %0d cycles", n);
        end
    endtask

    // steps until miss_pulse; returns cycles taken and whether a hit was seen
    task automatic wait_miss(output int n, output logic saw_hit);
        n = 0;
        saw_hit = 1'b0;
        while (!miss_pulse && n < 60) begin
            step();
            n++;
            if (hit_pulse) saw_hit = 1'b1;
        end
    endtask

    task automatic hit_round(input logic [1:0] rnd, input logic [3:0] mask);
        int n;
        rnd_num = rnd;
        wait_mole(n);
        btn = mask;
        step();
        btn = 4'd0;
        step();
    endtask

    task automatic test_reset();
        int n;
        apply_reset();
        compared++;
        if ({mole, score, misses, busy, game_over, hit_pulse, miss_pulse} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_idle: got %0h want 0",
                     {mole, score, misses, busy, game_over, hit_pulse, miss_pulse});
        end
        do_start();
        hit_round(2'd0, 4'b0001);
        hit_round(2'd1, 4'b0010);
        rnd_num = 2'd2;
        wait_mole(n);
        compared++;
        if (score !== 8'd2 || mole !== 4'b0100) begin
            mismatched++;
            $display("FAIL reset_pre: score %0d mole %b want 2 0100", score, mole);
        end
        reset = 1'b0;
        step();
        compared++;
        if ({mole, score, misses, busy, game_over, hit_pulse, miss_pulse} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_midgame: got %0h want 0",
                     {mole, score, misses, busy, game_over, hit_pulse, miss_pulse});
        end
        reset = 1'b1;
        step();
        step();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_stays_idle: busy %b want 0", busy);
        end
        do_start();
        compared++;
        if (busy !== 1'b1 || score !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_restart: busy %b score %0d want 1 0", busy, score);
        end
        wait_mole(n);
        compared++;
        if (mole !== 4'b0100) begin
            mismatched++;
            $display("FAIL reset_first_mole: mole %b want 0100", mole);
        end
    endtask

    task automatic test_hit();
        int n;
        apply_reset();
        rnd_num = 2'd2;
        do_start();
        compared++;
        if (busy !== 1'b1 || mole !== 4'd0) begin
            mismatched++;
            $display("FAIL start_latency: busy %b mole %b want 1 0000", busy, mole);
        end
        wait_mole(n);
        compared++;
        if (n !== 8 || mole !== 4'b0100) begin
            mismatched++;
            $display("FAIL gap_len: cycles %0d mole %b want 8 0100", n, mole);
        end
        step();
        step();
        btn = 4'b0100;
        step();
        compared++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || mole !== 4'd0) begin
            mismatched++;
            $display("FAIL hit: hit %b miss %b score %0d mole %b want 1 0 1 0000",
                     hit_pulse, miss_pulse, score, mole);
        end
        btn = 4'd0;
        step();
        compared++;
        if (hit_pulse !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL hit_pulse_width: hit %b busy %b want 0 1", hit_pulse, busy);
        end
    endtask

    task automatic test_norepeat_timeout();
        int   n;
        int   m;
        logic saw;
        apply_reset();
        rnd_num = 2'd1;
        do_start();
        wait_mole(n);
        compared++;
        if (mole !== 4'b0010) begin
            mismatched++;
            $display("FAIL first_mole: mole %b want 0010", mole);
        end
        wait_miss(m, saw);
        compared++;
        if (m !== 12 || mole !== 4'd0 || misses !== 4'd1 || saw) begin
            mismatched++;
            $display("FAIL timeout1: cycles %0d mole %b misses %0d hit %b want 12 0000 1 0",
                     m, mole, misses, saw);
        end
        wait_mole(n);
        compared++;
        if (mole !== 4'b0100) begin
            mismatched++;
            $display("FAIL no_repeat: mole %b want 0100", mole);
        end
        wait_miss(m, saw);
        compared++;
        if (m !== 12 || misses !== 4'd2 || hit_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout2: cycles %0d misses %0d hit %b want 12 2 0", m, misses, hit_pulse);
        end
    endtask

    task automatic test_wrong_multi();
        int   n;
        int   m;
        logic saw;
        apply_reset();
        rnd_num = 2'd0;
        do_start();
        wait_mole(n);
        compared++;
        if (mole !== 4'b0001) begin
            mismatched++;
            $display("FAIL multi_mole: mole %b want 0001", mole);
        end
        step();
        btn = 4'b0011;
        step();
        compared++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 8'd0 || misses !== 4'd1) begin
            mismatched++;
            $display("FAIL multi_press: miss %b hit %b score %0d misses %0d want 1 0 0 1",
                     miss_pulse, hit_pulse, score, misses);
        end
        btn = 4'd0;
        rnd_num = 2'd3;
        wait_mole(n);
        for (int i = 0; i < 11; i++) step();
        btn = 4'b1000;
        step();
        compared++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || score !== 8'd1 || misses !== 4'd1) begin
            mismatched++;
            $display("FAIL timeout_press: hit %b miss %b score %0d misses %0d want 1 0 1 1",
                     hit_pulse, miss_pulse, score, misses);
        end
        btn = 4'd0;
        step();
        compared++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_press_one_pulse: hit %b miss %b want 0 0", hit_pulse, miss_pulse);
        end
        rnd_num = 2'd1;
        btn = 4'b0010;
        wait_mole(n);
        wait_miss(m, saw);
        compared++;
        if (m !== 12 || saw || score !== 8'd1 || misses !== 4'd2) begin
            mismatched++;
            $display("FAIL held_button: cycles %0d hit %b score %0d misses %0d want 12 0 1 2",
                     m, saw, score, misses);
        end
        btn = 4'd0;
        step();
    endtask

    task automatic test_game_end();
        int   n;
        int   m;
        logic saw;
        apply_reset();
        rnd_num = 2'd0;
        do_start();
        for (int r = 0; r < 3; r++) begin
            wait_mole(n);
            wait_miss(m, saw);
            if (r == 1) begin
                compared++;
                if (game_over !== 1'b0 || busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL miss_not_over: game_over %b busy %b want 0 1", game_over, busy);
                end
            end
        end
        compared++;
        if (game_over !== 1'b1 || busy !== 1'b0 || misses !== 4'd3 || mole !== 4'd0) begin
            mismatched++;
            $display("FAIL miss_end: game_over %b busy %b misses %0d mole %b want 1 0 3 0000",
                     game_over, busy, misses, mole);
        end
        step();
        step();
        compared++;
        if (game_over !== 1'b1 || misses !== 4'd3) begin
            mismatched++;
            $display("FAIL done_hold: game_over %b misses %0d want 1 3", game_over, misses);
        end
        do_start();
        compared++;
        if (game_over !== 1'b0 || busy !== 1'b1 || misses !== 4'd0 || score !== 8'd0) begin
            mismatched++;
            $display("FAIL done_restart: game_over %b busy %b misses %0d score %0d want 0 1 0 0",
                     game_over, busy, misses, score);
        end
        rnd_num = 2'd0;
        wait_mole(n);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        compared++;
        if (mole !== 4'b0001 || busy !== 1'b1 || score !== 8'd0) begin
            mismatched++;
            $display("FAIL start_in_show: mole %b busy %b score %0d want 0001 1 0", mole, busy, score);
        end
        btn = 4'b0001;
        step();
        btn = 4'd0;
        step();
        hit_round(2'd1, 4'b0010);
        hit_round(2'd2, 4'b0100);
        compared++;
        if (game_over !== 1'b0 || score !== 8'd3) begin
            mismatched++;
            $display("FAIL hits_not_over: game_over %b score %0d want 0 3", game_over, score);
        end
        hit_round(2'd3, 4'b1000);
        compared++;
        if (game_over !== 1'b1 || busy !== 1'b0 || score !== 8'd4 || misses !== 4'd0) begin
            mismatched++;
            $display("FAIL hit_end: game_over %b busy %b score %0d misses %0d want 1 0 4 0",
                     game_over, busy, score, misses);
        end
        rnd_num = 2'd3;
        do_start();
        compared++;
        if (score !== 8'd0 || game_over !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL hit_restart: score %0d game_over %b busy %b want 0 0 1",
                     score, game_over, busy);
        end
        wait_mole(n);
        compared++;
        if (mole !== 4'b1000) begin
            mismatched++;
            $display("FAIL restart_first_mole: mole %b want 1000", mole);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        start      = 1'b0;
        btn        = 4'd0;
        rnd_num    = 2'd0;
        test_reset();
        test_hit();
        test_norepeat_timeout();
        test_wrong_multi();
        test_game_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round sequencer for the whack-a-mole game. It samples the free-running 2-bit `random` generator to pick which of four moles lights. It holds that mole for a fixed window and judges the player's button presses as hit or miss. It also keeps score and a miss count, and ends the game after a fixed number of rounds or misses. It sits between `random` (mole source), the debounced push-buttons (player input) and the LED/display logic (mole lamps, score, status).

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clock cycles per game tick (≥1).
- `UP_TICKS`, 2: ticks a mole stays lit (≥1).
- `GAP_TICKS`, 1: ticks of dark gap before each mole (≥1).
- `ROUNDS`, 20: moles per game (1..255).
- `MAX_MISS`, 5: misses that end the game early (1..15).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  start/restart request; level input, acted on at its rising edge.
- `rnd_num`  in  2  current output of `random`; sampled, never driven.
- `btn`  in  4  debounced buttons, active-high, bit i = mole i.
- `mole`  out  4  one-hot lit mole, 0 when none.
- `score`  out  8  hits this game, saturates at 255.
- `misses`  out  4  misses this game.
- `busy`  out  1  high in GAP or SHOW.
- `game_over`  out  1  high in DONE.
- `hit_pulse`  out  1  one-cycle pulse per hit.
- `miss_pulse`  out  1  one-cycle pulse per miss.

## Operation
- States: IDLE, GAP, SHOW, DONE. Outputs are registered.
- Reset (`reset`=0 at a clock edge) sets the following, all taking effect at that edge:
  - state to IDLE;
  - `mole`, `score` and `misses` to 0;
  - `busy`, `game_over`, `hit_pulse` and `miss_pulse` to 0;
  - the round counter and cycle timer to 0;
  - the `start` and `btn` edge registers to 0.
- Reset mid-game abandons the game immediately.
- Edge detect: `start_q` and `btn_q` are the inputs registered every cycle. A rising edge is `x & ~x_q`.
- IDLE or DONE, with a `start` rising edge:
  - clear `score`, `misses` and the round counter;
  - clear the timer;
  - go to GAP.
- In all other states a `start` edge is ignored.
- GAP: `mole`=0. The timer counts cycles. When the timer reaches GAP_TICKS·TICK_DIV−1:
  - pick mole index p = `rnd_num`;
  - if p equals the previous mole index of this game, use p+1 mod 4 instead (no repeat); the first mole of a game is never adjusted;
  - load `mole` = 1<<p, clear the timer, go to SHOW.
- SHOW: the lit mole is held. Each cycle, let e = `btn` edge mask.
  - e == `mole`: hit. `score`+1 (saturating at 255) and `hit_pulse`=1.
  - e ≠ 0 and e ≠ `mole` (wrong button, or several buttons in the same cycle): miss. `misses`+1 and `miss_pulse`=1.
  - e == 0 and the timer reaches UP_TICKS·TICK_DIV−1: miss (timeout).
  - A press in the timeout cycle is judged as a press; the timeout is ignored.
- On any hit or miss:
  - `mole`=0, round+1, timer cleared;
  - if the new round count == ROUNDS, or the new miss count == MAX_MISS, go to DONE; otherwise go to GAP.
- DONE: `mole`=0, `game_over`=1. `score` and `misses` hold until the next start.
- Button edges outside SHOW are discarded. A button held from GAP into SHOW does not count; the player must release and press again.

## Timing
- GAP lasts exactly GAP_TICKS·TICK_DIV cycles. `mole` becomes nonzero on the clock edge that ends GAP.
- An unanswered SHOW lasts exactly UP_TICKS·TICK_DIV cycles. `mole` returns to 0 on the edge that records the miss.
- Press latency: the `btn` rising edge is sampled at edge k. At edge k the following all take effect together:
  - `hit_pulse`/`miss_pulse`=1, `score`/`misses` are updated, `mole`=0;
  - `hit_pulse`/`miss_pulse` drop at edge k+1.
- Start latency: a `start` rising edge sampled at edge k puts the block in GAP, with `busy`=1, from edge k.
- `busy` and `game_over` track state with no extra delay.
- At most one of `hit_pulse`/`miss_pulse` is high in any cycle. Each judged mole produces exactly one pulse.

## Test plan
Parameters for all scenarios: TICK_DIV=4, UP_TICKS=3, GAP_TICKS=2, ROUNDS=4, MAX_MISS=3.

- Reset: drive `reset`=0 mid-SHOW with `score`=2. At the next edge all outputs are 0 and state is IDLE. A `start` edge then restarts with `score`=0.
- Hit timing: `start` edge, `rnd_num`=2.
  - `mole`=4'b0100 exactly 8 cycles after start.
  - Press `btn`=4'b0100 on cycle 3 of SHOW: `hit_pulse` high for one cycle, `score`=1, `mole`=0 in that same cycle.
- No-repeat and timeout: hold `rnd_num`=1 for two rounds with no presses.
  - First `mole`=4'b0010, second `mole`=4'b0100.
  - Each SHOW lasts exactly 12 cycles, then `miss_pulse`; `misses`=2.
- Wrong and multi press:
  - `mole`=4'b0001 with `btn`=4'b0011 gives a miss, not a hit.
  - A press exactly in the timeout cycle counts as a hit with only one pulse.
  - A button held from GAP into SHOW scores nothing.
- Game end:
  - 3 consecutive timeouts give `game_over`=1 after round 3 with `misses`=3.
  - In a separate run, 4 hits give `game_over`=1 with `score`=4.
  - `start` edges during SHOW are ignored; a `start` edge in DONE restarts the game.
